// File: rtl/sram_req_arbiter.sv
// Arbitrates instruction-fetch and data sram-like ports onto one sram-like master port.
// Data has priority, with a starvation limit for fetch; a routing FIFO steers responses back.
//
// owner    | meaning
// ---------+--------------------------------------------------------------
// OWN_NONE | unlocked: winner picked combinationally, 0-cycle grant
// OWN_INST | fetch request presented, waiting for m_addr_ok
// OWN_DATA | data request presented, waiting for m_addr_ok
module sram_req_arbiter #(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        err_unexp
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  owner_t              owner, owner_nxt, sel, winner;
  logic [MAX_OUTST-1:0] route_is_inst;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [SW-1:0]       starve_cnt;
  logic                full, empty, accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(MAX_OUTST));
  assign empty = (count == '0);

  always_comb begin
    winner = OWN_NONE;
    if (inst_req && (starve_cnt == SW'(STARVE_LIMIT)))
      winner = OWN_INST;
    else if (data_req)
      winner = OWN_DATA;
    else if (inst_req)
      winner = OWN_INST;
  end

  // A locked owner keeps the port; otherwise the fresh winner is granted in the same cycle.
  always_comb begin
    sel = owner;
    if (owner == OWN_NONE)
      sel = full ? OWN_NONE : winner;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) owner <= OWN_NONE;
    else         owner <= owner_nxt;
  end

  // Lock only while a presented request waits; after an accept the next cycle re-arbitrates,
  // which keeps back-to-back accepts possible with registered starvation state.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (m_req && !m_addr_ok)
      owner_nxt = sel;
  end

  always_comb begin
    m_req  = 1'b0;
    m_wr   = data_wr;
    m_size = data_size;
    m_addr = data_addr;
    m_wdata = data_wdata;
    if (sel == OWN_INST) begin
      m_req   = inst_req;
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
    end else if (sel == OWN_DATA) begin
      m_req = data_req;
    end
    // Outputs must read zero while reset is held, even with requests still asserted.
    m_req = m_req && resetn;
  end

  assign accept       = m_req && m_addr_ok;
  assign push         = accept;
  assign pop          = m_data_ok && !empty;
  assign inst_addr_ok = accept && (sel == OWN_INST);
  assign data_addr_ok = accept && (sel == OWN_DATA);
  assign inst_data_ok = pop && route_is_inst[rd_ptr];
  assign data_data_ok = pop && !route_is_inst[rd_ptr];
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      route_is_inst <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      if (push) begin
        route_is_inst[wr_ptr] <= (sel == OWN_INST);
        wr_ptr                <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_unexp <= 1'b0;
    else if (m_data_ok && empty)
      err_unexp <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      starve_cnt <= '0;
    else if (inst_addr_ok || !inst_req)
      starve_cnt <= '0;
    else if (data_addr_ok && (starve_cnt != SW'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: drives both request ports and a scripted bridge,
// checking grants, routing, starvation, full handling, unexpected responses and reset.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok, err_unexp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .err_unexp(err_unexp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h0; data_wdata = 32'h0;
    m_rdata = 32'h0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    #12;
    chk("rst_m_req", m_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_err", err_unexp, 0);
    tick();
    resetn = 1'b1;

    // 1: single fetch read, response three cycles after accept
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
    #2;
    chk("t1_m_req", m_req, 1);
    chk("t1_m_addr", m_addr, 32'hBFC0_0000);
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 0; m_addr_ok = 0;
    tick();
    tick();
    m_data_ok = 1; m_rdata = 32'h1234_5678;
    #2;
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h1234_5678);
    chk("t1_data_data_ok", data_data_ok, 0);
    tick();
    m_data_ok = 0;

    // 2: simultaneous requests, data first then fetch; responses routed in order
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wdata = 32'hCAFE_F00D;
    m_addr_ok = 1;
    #2;
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok0", inst_addr_ok, 0);
    chk("t2_m_addr_data", m_addr, 32'h8000_0010);
    chk("t2_m_wr", m_wr, 1);
    chk("t2_m_wdata", m_wdata, 32'hCAFE_F00D);
    tick();
    data_req = 0; data_wr = 0;
    #2;
    chk("t2_inst_addr_ok1", inst_addr_ok, 1);
    chk("t2_m_addr_inst", m_addr, 32'hBFC0_0004);
    tick();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hAAAA_0001;
    #2;
    chk("t2_resp0_data", data_data_ok, 1);
    chk("t2_resp0_inst", inst_data_ok, 0);
    tick();
    m_rdata = 32'hBBBB_0002;
    #2;
    chk("t2_resp1_inst", inst_data_ok, 1);
    chk("t2_resp1_data", data_data_ok, 0);
    chk("t2_resp1_rdata", inst_rdata, 32'hBBBB_0002);
    tick();
    m_data_ok = 0;

    // 3: starvation limit forces fetch on the fifth accept, then data resumes
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    data_req = 1; data_addr = 32'h8000_0200;
    m_addr_ok = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) inst_req = 0;
      m_data_ok = (i != 0);
      #2;
      chk($sformatf("t3_data_addr_ok%0d", i), data_addr_ok, (i != 4));
      chk($sformatf("t3_inst_addr_ok%0d", i), inst_addr_ok, (i == 4));
      if (i != 0) chk($sformatf("t3_inst_data_ok%0d", i), inst_data_ok, (i == 5));
      tick();
    end
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #2;
    chk("t3_drain_data", data_data_ok, 1);
    tick();
    m_data_ok = 0;

    // 4: two outstanding fill the FIFO; a pop frees the slot only on the following cycle
    data_req = 1; data_addr = 32'h8000_0300; m_addr_ok = 1;
    #2;
    chk("t4_acc0", data_addr_ok, 1);
    tick();
    #2;
    chk("t4_acc1", data_addr_ok, 1);
    tick();
    #2;
    chk("t4_full_m_req", m_req, 0);
    chk("t4_full_addr_ok", data_addr_ok, 0);
    tick();
    m_data_ok = 1;
    #2;
    chk("t4_pop_m_req", m_req, 0);
    chk("t4_pop_data_ok", data_data_ok, 1);
    tick();
    m_data_ok = 0;
    #2;
    chk("t4_acc2", data_addr_ok, 1);
    tick();
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #2;
    chk("t4_drain0", data_data_ok, 1);
    tick();
    #2;
    chk("t4_drain1", data_data_ok, 1);
    tick();
    m_data_ok = 0;

    // 5: unexpected response is dropped and sticky; reset mid-burst clears everything
    chk("t5_err_before", err_unexp, 0);
    m_data_ok = 1;
    #2;
    chk("t5_unexp_inst_ok", inst_data_ok, 0);
    chk("t5_unexp_data_ok", data_data_ok, 0);
    tick();
    m_data_ok = 0;
    tick();
    chk("t5_err_sticky", err_unexp, 1);
    data_req = 1; data_addr = 32'h8000_0400; m_addr_ok = 1;
    tick();
    m_data_ok = 1;
    resetn = 0;
    #2;
    chk("t5_rst_m_req", m_req, 0);
    chk("t5_rst_addr_ok", data_addr_ok, 0);
    chk("t5_rst_data_ok", data_data_ok, 0);
    chk("t5_rst_err", err_unexp, 0);
    tick();
    resetn = 1; data_req = 0; m_addr_ok = 0;
    #2;
    chk("t5_empty_data_ok", data_data_ok, 0);
    tick();
    m_data_ok = 0;
    chk("t5_empty_err", err_unexp, 1);
    resetn = 0;
    tick();
    resetn = 1;
    tick();

    // 6: bridge stalls; locked data request stays on the port while fetch waits
    data_req = 1; data_addr = 32'h8000_0500; data_size = 2'd1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) inst_req = 1;
      inst_addr = 32'hBFC0_0200;
      #2;
      chk($sformatf("t6_m_addr%0d", i), m_addr, 32'h8000_0500);
      chk($sformatf("t6_m_size%0d", i), m_size, 1);
      chk($sformatf("t6_inst_ok%0d", i), inst_addr_ok, 0);
      tick();
    end
    m_addr_ok = 1;
    #2;
    chk("t6_data_accept", data_addr_ok, 1);
    tick();
    data_req = 0;
    #2;
    chk("t6_inst_accept", inst_addr_ok, 1);
    chk("t6_inst_m_addr", m_addr, 32'hBFC0_0200);
    tick();
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
